// File: rtl/ntt_layer_sequencer.sv
// Layer/butterfly sequencer for an in-place 7-layer Kyber NTT/INTT over a dual-port RAM.
// Issues one butterfly per cycle, tracks addresses through the read+butterfly latency, drains between layers.
module ntt_layer_sequencer #(
  parameter int BF_LAT = 7,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  output logic        busy,
  output logic        done,
  output logic        ram_rd_en,
  output logic [7:0]  ram_rd_addr_a,
  output logic [7:0]  ram_rd_addr_b,
  input  logic [11:0] ram_rd_data_a,
  input  logic [11:0] ram_rd_data_b,
  output logic [6:0]  zeta_idx,
  input  logic [11:0] zeta_in,
  output logic [1:0]  bf_operation,
  output logic        bf_valid_in,
  output logic [11:0] bf_a_in,
  output logic [11:0] bf_b_in,
  output logic [11:0] bf_zeta,
  input  logic [11:0] bf_a_out,
  input  logic [11:0] bf_b_out,
  input  logic        bf_valid_out,
  output logic        ram_wr_en,
  output logic [7:0]  ram_wr_addr_a,
  output logic [7:0]  ram_wr_addr_b,
  output logic [11:0] ram_wr_data_a,
  output logic [11:0] ram_wr_data_b,
  output logic        seq_err
);

  localparam int DEPTH = RD_LAT + BF_LAT;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t         state_r;
  logic           mode_r;
  logic [2:0]     layer_r;
  logic [6:0]     i_r;
  logic [6:0]     o_r;
  logic [7:0]     len_r;
  logic [DEPTH-1:0] dl_valid_r;
  logic [7:0]     dl_addr_a_r [DEPTH];
  logic [7:0]     dl_addr_b_r [DEPTH];
  logic [CW-1:0]  in_flight_r;

  logic           tail_valid_s;
  logic           err_s;
  logic           wrap_s;
  logic [7:0]     nxt_addr_a_s;
  logic [6:0]     nxt_zeta_s;
  logic [6:0]     layer_zeta_s;
  logic [7:0]     next_len_s;
  logic [CW-1:0]  in_flight_next_s;

  assign bf_a_in       = ram_rd_data_a;
  assign bf_b_in       = ram_rd_data_b;
  assign bf_zeta       = zeta_in;
  assign tail_valid_s  = dl_valid_r[DEPTH-1];
  assign ram_wr_en     = bf_valid_out & tail_valid_s;
  assign ram_wr_addr_a = dl_addr_a_r[DEPTH-1];
  assign ram_wr_addr_b = dl_addr_b_r[DEPTH-1];
  assign ram_wr_data_a = bf_a_out;
  assign ram_wr_data_b = bf_b_out;
  // Any disagreement between result strobe and tracked tail is a sequencing error.
  assign err_s         = bf_valid_out ^ tail_valid_s;

  // Next butterfly address/twiddle within a layer, and twiddle/len for the following layer.
  always_comb begin
    wrap_s       = ({1'b0, o_r} == (len_r - 8'd1));
    nxt_addr_a_s = ram_rd_addr_a + 8'd1;
    nxt_zeta_s   = zeta_idx;
    layer_zeta_s = mode_r ? (zeta_idx - 7'd1) : (zeta_idx + 7'd1);
    next_len_s   = mode_r ? {len_r[6:0], 1'b0} : {1'b0, len_r[7:1]};
    if (wrap_s) begin
      nxt_addr_a_s = ram_rd_addr_a + len_r + 8'd1;
      nxt_zeta_s   = layer_zeta_s;
    end else begin
      nxt_addr_a_s = ram_rd_addr_a + 8'd1;
      nxt_zeta_s   = zeta_idx;
    end
  end

  // In-flight count after this cycle's push/pop.
  always_comb begin
    in_flight_next_s = in_flight_r;
    case ({ram_rd_en, tail_valid_s})
      2'b10:   in_flight_next_s = in_flight_r + CNT_ONE;
      2'b01:   in_flight_next_s = in_flight_r - CNT_ONE;
      default: in_flight_next_s = in_flight_r;
    endcase
  end

  // Control FSM, registered outputs and address delay line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      mode_r        <= 1'b0;
      layer_r       <= 3'd0;
      i_r           <= 7'd0;
      o_r           <= 7'd0;
      len_r         <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ram_rd_en     <= 1'b0;
      ram_rd_addr_a <= 8'd0;
      ram_rd_addr_b <= 8'd0;
      zeta_idx      <= 7'd0;
      bf_operation  <= 2'b00;
      bf_valid_in   <= 1'b0;
      seq_err       <= 1'b0;
      in_flight_r   <= CNT_ZERO;
      dl_valid_r    <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        dl_addr_a_r[k] <= 8'd0;
        dl_addr_b_r[k] <= 8'd0;
      end
    end else begin
      dl_valid_r     <= {dl_valid_r[DEPTH-2:0], ram_rd_en};
      dl_addr_a_r[0] <= ram_rd_addr_a;
      dl_addr_b_r[0] <= ram_rd_addr_b;
      for (int k = 1; k < DEPTH; k++) begin
        dl_addr_a_r[k] <= dl_addr_a_r[k-1];
        dl_addr_b_r[k] <= dl_addr_b_r[k-1];
      end
      in_flight_r <= in_flight_next_s;
      bf_valid_in <= ram_rd_en;

      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_r        <= mode;
            bf_operation  <= {1'b0, mode};
            layer_r       <= 3'd0;
            i_r           <= 7'd0;
            o_r           <= 7'd0;
            len_r         <= mode ? 8'd2 : 8'd128;
            ram_rd_en     <= 1'b1;
            ram_rd_addr_a <= 8'd0;
            ram_rd_addr_b <= mode ? 8'd2 : 8'd128;
            zeta_idx      <= mode ? 7'd127 : 7'd1;
            busy          <= 1'b1;
            seq_err       <= 1'b0;
            state_r       <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (i_r == 7'd127) begin
            ram_rd_en <= 1'b0;
            state_r   <= DRAIN;
          end else begin
            i_r           <= i_r + 7'd1;
            o_r           <= wrap_s ? 7'd0 : (o_r + 7'd1);
            ram_rd_addr_a <= nxt_addr_a_s;
            ram_rd_addr_b <= nxt_addr_a_s + len_r;
            zeta_idx      <= nxt_zeta_s;
            state_r       <= ISSUE;
          end
        end
        DRAIN: begin
          // Next layer may read as soon as the last write of this layer has landed.
          if (in_flight_next_s == CNT_ZERO) begin
            if (layer_r == 3'd6) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= DONE;
            end else begin
              layer_r       <= layer_r + 3'd1;
              len_r         <= next_len_s;
              i_r           <= 7'd0;
              o_r           <= 7'd0;
              ram_rd_addr_a <= 8'd0;
              ram_rd_addr_b <= next_len_s;
              zeta_idx      <= layer_zeta_s;
              ram_rd_en     <= 1'b1;
              state_r       <= ISSUE;
            end
          end else begin
            state_r <= DRAIN;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      if (err_s) begin
        seq_err <= 1'b1;
      end
    end
  end

endmodule
